aes_shift_mix: RTL and testbench

Round stage placed directly after the byte-substitution stage in the AES-128 encryption datapath. It applies ShiftRows to the 128-bit substituted state, then MixColumns one 32-bit column per clock. The result is registered and passed to the AddRoundKey stage. For the final round (`final_in`=1), MixColumns is skipped and the ShiftRows result is emitted after one cycle.

---
 rtl/aes_pkg.sv | 36 +++
 rtl/mix_single_column.sv | 28 ++
 rtl/aes_shift_mix.sv | 105 ++++++++++
 tb/tb_aes_shift_mix.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the AES ShiftRows/MixColumns round stage.
// Byte (r,c) of a 128-bit state sits at bits 127-32c-8r downto 120-32c-8r.
package aes_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MIX  = 1'b1
  } state_e;

  localparam logic [7:0] AES_POLY = 8'h1B;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  // LSB position of byte (r,c): 120-32c-8r == 8*((3-c)*4 + (3-r)).
  function automatic logic [6:0] byte_lsb(input logic [1:0] r, input logic [1:0] c);
    return {~c, ~r, 3'b000};
  endfunction

  function automatic logic [6:0] col_lsb(input logic [1:0] c);
    return {~c, 5'b00000};
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[byte_lsb(2'(r), 2'(c)) +: 8] = s[byte_lsb(2'(r), 2'(c + r)) +: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational MixColumns on one 32-bit column; row 0 is the most significant byte.
module mix_single_column
  import aes_pkg::*;
(
  input  logic [31:0] i_col,
  output logic [31:0] o_col
);

  logic [7:0] w_a0, w_a1, w_a2, w_a3;
  logic [7:0] w_x0, w_x1, w_x2, w_x3;

  assign w_a0 = i_col[31:24];
  assign w_a1 = i_col[23:16];
  assign w_a2 = i_col[15:8];
  assign w_a3 = i_col[7:0];

  assign w_x0 = xtime(w_a0);
  assign w_x1 = xtime(w_a1);
  assign w_x2 = xtime(w_a2);
  assign w_x3 = xtime(w_a3);

  // 3a is written as xtime(a)^a.
  assign o_col[31:24] = w_x0 ^ (w_x1 ^ w_a1) ^ w_a2 ^ w_a3;
  assign o_col[23:16] = w_a0 ^ w_x1 ^ (w_x2 ^ w_a2) ^ w_a3;
  assign o_col[15:8]  = w_a0 ^ w_a1 ^ w_x2 ^ (w_x3 ^ w_a3);
  assign o_col[7:0]   = (w_x0 ^ w_a0) ^ w_a1 ^ w_a2 ^ w_x3;

endmodule

// File: rtl/aes_shift_mix.sv
// AES-128 ShiftRows + MixColumns round stage, one column per clock.
// Final rounds bypass MixColumns and emit the ShiftRows result after one cycle.
module aes_shift_mix
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_in,
  input  logic         final_in,
  input  logic [127:0] data_in,
  output logic         ready_out,
  output logic         valid_out,
  output logic [127:0] data_out
);

  state_e       r_state;
  state_e       w_next_state;
  logic [1:0]   r_col;
  logic [127:0] r_work;
  logic [127:0] r_data_out;
  logic         r_valid_out;

  logic         w_load_work;
  logic         w_emit_final;
  logic         w_emit_mix;
  logic [127:0] w_shifted;
  logic [31:0]  w_col_in;
  logic [31:0]  w_col_out;
  logic [127:0] w_work_mixed;

  assign w_shifted = shift_rows(data_in);
  assign w_col_in  = r_work[col_lsb(r_col) +: 32];

  mix_single_column u_mix (
    .i_col (w_col_in),
    .o_col (w_col_out)
  );

  always_comb begin
    w_work_mixed = r_work;
    w_work_mixed[col_lsb(r_col) +: 32] = w_col_out;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load_work  = 1'b0;
    w_emit_final = 1'b0;
    w_emit_mix   = 1'b0;
    case (r_state)
      IDLE: begin
        if (valid_in) begin
          if (final_in) begin
            w_emit_final = 1'b1;
          end else begin
            w_load_work  = 1'b1;
            w_next_state = MIX;
          end
        end
      end
      MIX: begin
        if (r_col == 2'd3) begin
          w_emit_mix   = 1'b1;
          w_next_state = IDLE;
        end
      end
    endcase
  end

  // The output register only moves on an emit, so partial columns never leak out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col       <= 2'd0;
      r_work      <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
    end else begin
      r_valid_out <= w_emit_final | w_emit_mix;
      if (w_load_work) begin
        r_work <= w_shifted;
        r_col  <= 2'd0;
      end else if (r_state == MIX) begin
        r_work <= w_work_mixed;
        r_col  <= r_col + 2'd1;
      end
      if (w_emit_final) begin
        r_data_out <= w_shifted;
      end else if (w_emit_mix) begin
        r_data_out <= w_work_mixed;
      end
    end
  end

  assign ready_out = (r_state == IDLE);
  assign valid_out = r_valid_out;
  assign data_out  = r_data_out;

endmodule

// File: tb/tb_aes_shift_mix.sv
// Self-checking bench for aes_shift_mix: directed FIPS-197 vectors, protocol corner
// cases and random blocks against a polynomial-arithmetic reference model.
module tb_aes_shift_mix;

  logic         clk;
  logic         reset;
  logic         valid_in;
  logic         final_in;
  logic [127:0] data_in;
  logic         ready_out;
  logic         valid_out;
  logic [127:0] data_out;

  int vectors;
  int miscompares;

  aes_shift_mix dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .final_in  (final_in),
    .data_in   (data_in),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .data_out  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full GF(2^8) product: carry-less multiply then reduce by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input int k);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (k[i]) p ^= (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p ^= (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] getByte(input logic [127:0] s, input int r, input int c);
    return s[127 - 32*c - 8*r -: 8];
  endfunction

  function automatic logic [127:0] refShift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 32*c - 8*r -: 8] = getByte(s, r, (c + r) % 4);
    return o;
  endfunction

  function automatic logic [127:0] refMix(input logic [127:0] s);
    int coef[4];
    logic [127:0] o;
    logic [7:0] acc;
    coef = '{2, 3, 1, 1};
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc ^= gmul(getByte(s, k, c), coef[(k - r + 4) % 4]);
        o[127 - 32*c - 8*r -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] refRound(input logic [127:0] d, input logic fin);
    return fin ? refShift(d) : refMix(refShift(d));
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where valid_out is seen.
  task automatic applyStimulus(input string tag, input logic [127:0] d, input logic fin,
                               input logic [127:0] expData);
    int edges;
    valid_in = 1'b1;
    final_in = fin;
    data_in  = d;
    edges    = 0;
    do begin
      @(negedge clk);
      edges++;
      if (edges == 1) valid_in = 1'b0;
    end while (!valid_out && edges < 12);
    checkOutput({tag, "_latency"}, 128'(edges), fin ? 128'd1 : 128'd5);
    checkOutput({tag, "_data"}, data_out, expData);
    checkOutput({tag, "_ready"}, 128'(ready_out), 128'd1);
  endtask

  localparam logic [127:0] FIPS_IN  = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
  localparam logic [127:0] FIPS_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] FIN_IN   = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] FIN_OUT  = 128'h00050a0f_04090e03_080d0207_0c01060b;

  initial begin
    logic [127:0] blkA, blkB, blkC, d, col;
    logic         fin;
    logic         sawPulse;
    int           edges;

    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    valid_in    = 1'b0;
    final_in    = 1'b0;
    data_in     = '0;

    #3;
    checkOutput("reset_valid", 128'(valid_out), 128'd0);
    checkOutput("reset_data", data_out, 128'd0);
    checkOutput("reset_ready", 128'(ready_out), 128'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    applyStimulus("fips_round1", FIPS_IN, 1'b0, FIPS_OUT);
    @(negedge clk);
    checkOutput("fips_single_pulse", 128'(valid_out), 128'd0);
    checkOutput("fips_hold", data_out, FIPS_OUT);

    applyStimulus("final_round", FIN_IN, 1'b1, FIN_OUT);
    @(negedge clk);

    applyStimulus("all_c6", {16{8'hc6}}, 1'b0, {16{8'hc6}});
    @(negedge clk);

    // Place db,13,53,45 so that ShiftRows gathers them into column 0.
    col = '0;
    col[127 -: 8] = 8'hdb;
    col[87 -: 8]  = 8'h13;
    col[47 -: 8]  = 8'h53;
    col[7 -: 8]   = 8'h45;
    applyStimulus("col_db135345", col, 1'b0, {32'h8e4da1bc, 96'h0});
    @(negedge clk);

    blkA = {$urandom, $urandom, $urandom, $urandom};
    blkB = {$urandom, $urandom, $urandom, $urandom};
    blkC = {$urandom, $urandom, $urandom, $urandom};
    valid_in = 1'b1;
    final_in = 1'b0;
    data_in  = blkA;
    @(negedge clk);
    checkOutput("bp_busy_e0", 128'(ready_out), 128'd0);
    data_in = blkC;
    @(negedge clk);
    checkOutput("bp_no_early_valid", 128'(valid_out), 128'd0);
    @(negedge clk);
    data_in = blkB;
    @(negedge clk);
    checkOutput("bp_busy_e3", 128'(ready_out), 128'd0);
    @(negedge clk);
    checkOutput("bp_first_valid", 128'(valid_out), 128'd1);
    checkOutput("bp_first_data", data_out, refRound(blkA, 1'b0));
    checkOutput("bp_ready_on_valid", 128'(ready_out), 128'd1);
    @(negedge clk);
    valid_in = 1'b0;
    checkOutput("bp_second_accepted", 128'(ready_out), 128'd0);
    checkOutput("bp_first_holds", data_out, refRound(blkA, 1'b0));
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
    end while (!valid_out && edges < 12);
    checkOutput("bp_second_latency", 128'(edges), 128'd4);
    checkOutput("bp_second_data", data_out, refRound(blkB, 1'b0));
    @(negedge clk);

    applyStimulus("pre_abort", FIN_IN, 1'b1, FIN_OUT);
    valid_in = 1'b1;
    final_in = 1'b0;
    data_in  = FIPS_IN;
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("abort_valid", 128'(valid_out), 128'd0);
    checkOutput("abort_data", data_out, 128'd0);
    checkOutput("abort_ready", 128'(ready_out), 128'd1);
    @(negedge clk);
    reset = 1'b1;
    sawPulse = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (valid_out) sawPulse = 1'b1;
    end
    checkOutput("abort_no_pulse", 128'(sawPulse), 128'd0);
    applyStimulus("after_abort", FIPS_IN, 1'b0, FIPS_OUT);
    @(negedge clk);

    applyStimulus("alt_final_a", blkA, 1'b1, refRound(blkA, 1'b1));
    applyStimulus("alt_normal", blkB, 1'b0, refRound(blkB, 1'b0));
    applyStimulus("alt_final_b", blkC, 1'b1, refRound(blkC, 1'b1));
    @(negedge clk);
    checkOutput("alt_pulse_end", 128'(valid_out), 128'd0);

    valid_in = 1'b1;
    final_in = 1'b1;
    data_in  = blkA;
    @(negedge clk);
    checkOutput("b2b_final0_valid", 128'(valid_out), 128'd1);
    checkOutput("b2b_final0_data", data_out, refShift(blkA));
    data_in = blkB;
    @(negedge clk);
    checkOutput("b2b_final1_valid", 128'(valid_out), 128'd1);
    checkOutput("b2b_final1_data", data_out, refShift(blkB));
    data_in = blkC;
    @(negedge clk);
    valid_in = 1'b0;
    checkOutput("b2b_final2_valid", 128'(valid_out), 128'd1);
    checkOutput("b2b_final2_data", data_out, refShift(blkC));
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      d   = {$urandom, $urandom, $urandom, $urandom};
      fin = 1'($urandom_range(0, 1));
      applyStimulus($sformatf("rand%0d", i), d, fin, refRound(d, fin));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
